// File: rtl/pong_round_if.sv
// pong_round_if: game-flow signals between the ball datapath/display and the round controller
interface pong_round_if;
  logic       Start;
  logic       Miss_Left;
  logic       Miss_Right;
  logic       Paddle_Hit;
  logic       Ball_Enable;
  logic       Ball_Recenter;
  logic       Serve_Go;
  logic       Serve_Dir;
  logic [1:0] Speed_Level;
  logic [3:0] Score1;
  logic [3:0] Score2;
  logic [1:0] Winner;
  logic [2:0] State;
  modport master (
    output Start, Miss_Left, Miss_Right, Paddle_Hit,
    input  Ball_Enable, Ball_Recenter, Serve_Go, Serve_Dir, Speed_Level, Score1, Score2, Winner, State
  );
  modport slave (
    input  Start, Miss_Left, Miss_Right, Paddle_Hit,
    output Ball_Enable, Ball_Recenter, Serve_Go, Serve_Dir, Speed_Level, Score1, Score2, Winner, State
  );
endinterface

// File: rtl/pong_round_ctrl.sv
// pong_round_ctrl: serve/rally/point/game-over sequencer with scores and rally speed level
module pong_round_ctrl #(
  parameter int WIN_SCORE      = 9,
  parameter int SERVE_DELAY    = 60,
  parameter int POINT_HOLD     = 30,
  parameter int HITS_PER_LEVEL = 4,
  parameter int MAX_LEVEL      = 3
) (
  input logic         frame_clk,
  input logic         Reset_n,
  pong_round_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;
  localparam logic [7:0] SD_END = 8'(SERVE_DELAY - 1);
  localparam logic [7:0] PH_END = 8'(POINT_HOLD - 1);
  localparam logic [7:0] HL_END = 8'(HITS_PER_LEVEL - 1);
  localparam logic [3:0] WIN    = 4'(WIN_SCORE);
  localparam logic [1:0] ML     = 2'(MAX_LEVEL);
  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, hits_q, hits_d;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0] speed_q, speed_d, winner_q, winner_d;
  logic       dir_q, dir_d, start_q, go_q, go_d, start_edge, miss;
  // next-state, scoring and speed-level logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hits_d     = hits_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    speed_d    = speed_q;
    winner_d   = winner_q;
    dir_d      = dir_q;
    go_d       = 1'b0;
    start_edge = bus.Start & ~start_q;
    miss       = bus.Miss_Left | bus.Miss_Right;
    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          state_d  = SERVE;
          s1_d     = '0;
          s2_d     = '0;
          winner_d = '0;
          dir_d    = 1'b0;
        end
      end
      SERVE: begin
        cnt_d   = cnt_q + 8'd1;
        hits_d  = '0;
        speed_d = '0;
        if (cnt_q == SD_END) begin
          state_d = PLAY;
          go_d    = 1'b1;
        end
      end
      PLAY: begin
        if (miss) begin
          state_d = POINT;
          s1_d    = (bus.Miss_Right & ~bus.Miss_Left) ? s1_q + 4'd1 : s1_q;
          s2_d    = (bus.Miss_Left & ~bus.Miss_Right) ? s2_q + 4'd1 : s2_q;
          dir_d   = (bus.Miss_Left ^ bus.Miss_Right) ? bus.Miss_Right : dir_q;
        end else if (bus.Paddle_Hit) begin
          hits_d  = (hits_q == HL_END) ? 8'd0 : hits_q + 8'd1;
          speed_d = (hits_q == HL_END && speed_q != ML) ? speed_q + 2'd1 : speed_q;
        end
      end
      POINT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == PH_END) begin
          state_d  = (s1_q == WIN || s2_q == WIN) ? OVER : SERVE;
          winner_d = (s1_q == WIN) ? 2'b01 : (s2_q == WIN) ? 2'b10 : 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end
  // state and datapath registers
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hits_q   <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      speed_q  <= '0;
      winner_q <= '0;
      dir_q    <= 1'b0;
      start_q  <= 1'b0;
      go_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hits_q   <= hits_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      speed_q  <= speed_d;
      winner_q <= winner_d;
      dir_q    <= dir_d;
      start_q  <= bus.Start;
      go_q     <= go_d;
    end
  end
  assign bus.State         = state_q;
  assign bus.Ball_Enable   = (state_q == PLAY);
  assign bus.Ball_Recenter = (state_q != PLAY);
  assign bus.Serve_Go      = go_q;
  assign bus.Serve_Dir     = dir_q;
  assign bus.Speed_Level   = speed_q;
  assign bus.Score1        = s1_q;
  assign bus.Score2        = s2_q;
  assign bus.Winner        = winner_q;
endmodule

// File: doc/pong_round_ctrl.md
Name: pong_round_ctrl

Overview:
- Game-flow controller for the pong datapath: sequences the ball through serve, rally, point-scored and game-over phases, keeps both players' scores and raises ball speed level as a rally lengthens.
- Sits between the ball motion block, which reports edge exits and paddle hits and takes enable/recenter/serve/speed controls, and the score display.
- Clocked by frame_clk (one tick per video frame).

Parameters:
- WIN_SCORE, 9, score at which a player wins (1..15)
- SERVE_DELAY, 60, frames the ball is held at centre before each serve
- POINT_HOLD, 30, frames held after a point before the next serve or game over
- HITS_PER_LEVEL, 4, paddle hits per speed-level increment
- MAX_LEVEL, 3, saturation value of Speed_Level

Ports:
- frame_clk  in  1  frame clock
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  start/restart button, level; rising edge detected internally
- Miss_Left  in  1  1-cycle pulse: ball exited left edge (player 2 scores)
- Miss_Right  in  1  1-cycle pulse: ball exited right edge (player 1 scores)
- Paddle_Hit  in  1  1-cycle pulse: ball bounced off either paddle
- Ball_Enable  out  1  ball may move (PLAY only)
- Ball_Recenter  out  1  hold ball at centre, step reset to start values
- Serve_Go  out  1  1-cycle pulse on SERVE→PLAY transition
- Serve_Dir  out  1  0 = serve toward -X (left), 1 = toward +X (right)
- Speed_Level  out  2  ball step boost, 0..MAX_LEVEL
- Score1  out  4  player 1 (left) score
- Score2  out  4  player 2 (right) score
- Winner  out  2  00 none, 01 player 1, 10 player 2
- State  out  3  debug state code: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

Behaviour:
- Reset (Reset_n low, async): State=IDLE, Score1=Score2=0, Winner=00, Serve_Dir=0, Speed_Level=0, frame counter=0, hit counter=0, Start edge register=0. Outputs take these values immediately; Ball_Recenter=1, Ball_Enable=0, Serve_Go=0. Deassertion is registered on the next frame_clk.
- Start_edge = Start & ~Start_q; Start_q is registered every cycle.
- IDLE: Start_edge -> SERVE, counter=0, scores cleared.
- SERVE: counter increments each cycle. When counter==SERVE_DELAY-1 -> PLAY, Serve_Go=1 for exactly that transition cycle. Speed_Level and hit counter are held at 0.
- PLAY: Ball_Enable=1, Ball_Recenter=0.
  - Paddle_Hit increments the hit counter. On reaching HITS_PER_LEVEL, the hit counter returns to 0 and Speed_Level increments, saturating at MAX_LEVEL.
  - Miss_Right only: Score1+1, Serve_Dir=1 (serve toward the loser), -> POINT, counter=0.
  - Miss_Left only: Score2+1, Serve_Dir=0, -> POINT.
  - Both misses in the same cycle: no score change, Serve_Dir unchanged, -> POINT.
  - A miss takes priority over a Paddle_Hit in the same cycle; that hit is discarded.
- POINT: counter counts to POINT_HOLD-1.
  - If Score1 or Score2 == WIN_SCORE -> OVER, Winner set (01 or 10).
  - Otherwise -> SERVE, counter=0.
- OVER: Ball_Recenter=1. Scores and Winner are held.
  - Start_edge -> SERVE with scores=0, Winner=00, Serve_Dir=0.
- Outside PLAY: Miss_Left, Miss_Right and Paddle_Hit are ignored. Ball_Recenter=1 and Ball_Enable=0 in every state except PLAY.
- Scores cannot exceed WIN_SCORE, because OVER is entered before any further point.
- Start_edge in SERVE, PLAY or POINT is ignored.
- Counter is 8 bits and is cleared on every state entry. It never wraps, because the parameters are <=255.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset mid-PLAY with Score1=3: assert Reset_n=0 -> State=0, Score1=0, Ball_Enable=0 immediately. Release, pulse Start -> SERVE; Serve_Go fires exactly 60 cycles after State=1.
- In PLAY, pulse Miss_Right -> next cycle Score1=1, Serve_Dir=1, State=3. 30 cycles later State=1. 60 cycles after that, Serve_Go=1 and State=2.
- In PLAY, 9 Paddle_Hit pulses -> Speed_Level goes 0→1 after hit 4 and →2 after hit 8. Then a Miss_Left -> Score2=1, and Speed_Level=0 at the next SERVE.
- 14 hits in one rally -> Speed_Level saturates at 3 and stays 3.
- Miss_Left and Miss_Right in the same cycle -> scores unchanged, State=3, Serve_Dir unchanged.
- Drive Score2 to 9 via misses -> after POINT hold, State=4 and Winner=10. Misses and hits are then ignored. Start rising edge -> Score1=Score2=0, Winner=00, State=1. Start held high produces no second restart.
